// File: rtl/cache_arbiter_pkg.sv
// Shared cpu types for the cache/RAM arbiter: RAM handshake, arbiter states, grant owner.
package cache_arbiter_pkg;

    localparam int unsigned WORD_W = 32;

    typedef logic [WORD_W-1:0] word_t;

    typedef enum logic [1:0] {
        FREE   = 2'd0,
        BUSY   = 2'd1,
        ACCESS = 2'd2,
        ERROR  = 2'd3
    } ramstate_t;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        IGNT  = 2'd1,
        DGNT  = 2'd2,
        DLOCK = 2'd3
    } arb_state_t;

    typedef enum logic {
        GRANT_I = 1'b0,
        GRANT_D = 1'b1
    } grant_t;

    // One RAM-port request as forwarded from the granted cache
    typedef struct packed {
        logic  ren;
        logic  wen;
        word_t addr;
        word_t store;
    } ram_req_t;

endpackage

// File: rtl/cache_arbiter_pick.sv
// Combinational two-requester picker: dcache-first, or round-robin when CACHE_ARB_RR_EN is defined.
module cache_arb_pick
    import cache_arbiter_pkg::*;
(
    input  logic   i_req,
    input  logic   d_req,
`ifdef CACHE_ARB_RR_EN
    input  grant_t last_grant,
`endif
    output logic   valid_c,
    output grant_t pick_c
);

    always_comb begin
        valid_c = i_req | d_req;
        pick_c  = GRANT_D;
        if (!d_req) pick_c = GRANT_I;
`ifdef CACHE_ARB_RR_EN
        // On a tie, hand the port to whoever did not have it last
        else if (i_req && (last_grant == GRANT_D)) pick_c = GRANT_I;
`endif
    end

endmodule

// File: rtl/cache_arbiter.sv
// Single RAM port shared by icache and dcache; locks to dcache across two-word block transfers.
// Optional feature macro: CACHE_ARB_RR_EN (round-robin on simultaneous requests).
module cache_arbiter
    import cache_arbiter_pkg::*;
#(
    parameter int unsigned ADDR_W  = 32,
    parameter int unsigned BLK_BIT = 2
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              iREN,
    input  logic [ADDR_W-1:0] iaddr,
    output logic [ADDR_W-1:0] iload,
    output logic              iwait,
    input  logic              dREN,
    input  logic              dWEN,
    input  logic [ADDR_W-1:0] daddr,
    input  logic [ADDR_W-1:0] dstore,
    output logic [ADDR_W-1:0] dload,
    output logic              dwait,
    output logic              ramREN,
    output logic              ramWEN,
    output logic [ADDR_W-1:0] ramaddr,
    output logic [ADDR_W-1:0] ramstore,
    input  logic [ADDR_W-1:0] ramload,
    input  ramstate_t         ramstate
);

    arb_state_t state, next_state;
    ram_req_t   req_c;
    logic       d_req;
    logic       pick_valid;
    grant_t     pick;

    assign d_req = dREN | dWEN;

`ifdef CACHE_ARB_RR_EN
    grant_t last_grant;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            last_grant <= GRANT_I;
        end else if ((state == IDLE) && (next_state != IDLE)) begin
            last_grant <= (next_state == IGNT) ? GRANT_I : GRANT_D;
        end
    end
`endif

    cache_arb_pick u_pick (
        .i_req      (iREN),
        .d_req      (d_req),
`ifdef CACHE_ARB_RR_EN
        .last_grant (last_grant),
`endif
        .valid_c    (pick_valid),
        .pick_c     (pick)
    );

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state <= IDLE;
        else     state <= next_state;
    end

    // Strobes and waits follow the current grant combinationally so a completion costs no extra cycle
    always_comb begin
        next_state = state;
        req_c      = '0;
        iwait      = 1'b1;
        dwait      = 1'b1;
        iload      = '0;
        dload      = '0;
        case (state)
            IDLE: begin
                if (pick_valid) next_state = (pick == GRANT_D) ? DGNT : IGNT;
            end
            IGNT: begin
                if (!iREN) begin
                    next_state = IDLE;
                end else begin
                    req_c.ren  = 1'b1;
                    req_c.addr = WORD_W'(iaddr);
                    if (ramstate == ACCESS) begin
                        iwait      = 1'b0;
                        iload      = ramload;
                        next_state = IDLE;
                    end
                end
            end
            DGNT, DLOCK: begin
                if (!d_req) begin
                    next_state = IDLE;
                end else begin
                    req_c.ren   = dREN;
                    req_c.wen   = dWEN;
                    req_c.addr  = WORD_W'(daddr);
                    req_c.store = WORD_W'(dstore);
                    if (ramstate == ACCESS) begin
                        dwait = 1'b0;
                        dload = ramload;
                        // Word 0 of a block keeps the port for word 1
                        next_state = ((state == DGNT) && !daddr[BLK_BIT]) ? DLOCK : IDLE;
                    end
                end
            end
            default: next_state = IDLE;
        endcase
    end

    assign ramREN   = req_c.ren;
    assign ramWEN   = req_c.wen;
    assign ramaddr  = ADDR_W'(req_c.addr);
    assign ramstore = ADDR_W'(req_c.store);

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed, table-driven bench for cache_arbiter plus hand sequences for alternation and mid-transfer reset.
module tb_cache_arbiter;
    import cache_arbiter_pkg::*;

    logic        CLK;
    logic        RST;
    logic        iREN;
    logic [31:0] iaddr;
    logic [31:0] iload;
    logic        iwait;
    logic        dREN;
    logic        dWEN;
    logic [31:0] daddr;
    logic [31:0] dstore;
    logic [31:0] dload;
    logic        dwait;
    logic        ramREN;
    logic        ramWEN;
    logic [31:0] ramaddr;
    logic [31:0] ramstore;
    logic [31:0] ramload;
    ramstate_t   ramstate;

    int errors = 0;
    int checks = 0;

    localparam logic [31:0] J = 32'hFFFF_0000;

    cache_arbiter dut (
        .CLK      (CLK),
        .RST      (RST),
        .iREN     (iREN),
        .iaddr    (iaddr),
        .iload    (iload),
        .iwait    (iwait),
        .dREN     (dREN),
        .dWEN     (dWEN),
        .daddr    (daddr),
        .dstore   (dstore),
        .dload    (dload),
        .dwait    (dwait),
        .ramREN   (ramREN),
        .ramWEN   (ramWEN),
        .ramaddr  (ramaddr),
        .ramstore (ramstore),
        .ramload  (ramload),
        .ramstate (ramstate)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct {
        logic        iren;
        logic [31:0] iaddr;
        logic        dren;
        logic        dwen;
        logic [31:0] daddr;
        logic [31:0] dstore;
        logic [31:0] ramload;
        ramstate_t   rs;
        logic        e_ren;
        logic        e_wen;
        logic [31:0] e_addr;
        logic [31:0] e_store;
        logic        e_iwait;
        logic        e_dwait;
        logic [31:0] e_iload;
        logic [31:0] e_dload;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(input logic ir, input logic [31:0] ia, input logic dr, input logic dw,
                                input logic [31:0] da, input logic [31:0] ds, input logic [31:0] rl,
                                input ramstate_t rs, input logic er, input logic ew,
                                input logic [31:0] ea, input logic [31:0] es, input logic eiw,
                                input logic edw, input logic [31:0] eil, input logic [31:0] edl);
        vec_t v;
        v.iren = ir; v.iaddr = ia; v.dren = dr; v.dwen = dw; v.daddr = da; v.dstore = ds;
        v.ramload = rl; v.rs = rs; v.e_ren = er; v.e_wen = ew; v.e_addr = ea; v.e_store = es;
        v.e_iwait = eiw; v.e_dwait = edw; v.e_iload = eil; v.e_dload = edl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        iREN = v.iren; iaddr = v.iaddr; dREN = v.dren; dWEN = v.dwen;
        daddr = v.daddr; dstore = v.dstore; ramload = v.ramload; ramstate = v.rs;
    endtask

    task automatic check_all(input string tag, input vec_t v);
        check({tag, " ramREN"},   32'(ramREN),  32'(v.e_ren));
        check({tag, " ramWEN"},   32'(ramWEN),  32'(v.e_wen));
        check({tag, " ramaddr"},  ramaddr,      v.e_addr);
        check({tag, " ramstore"}, ramstore,     v.e_store);
        check({tag, " iwait"},    32'(iwait),   32'(v.e_iwait));
        check({tag, " dwait"},    32'(dwait),   32'(v.e_dwait));
        check({tag, " iload"},    iload,        v.e_iload);
        check({tag, " dload"},    dload,        v.e_dload);
    endtask

    task automatic idle_inputs();
        iREN = 0; iaddr = '0; dREN = 0; dWEN = 0; daddr = '0; dstore = '0;
        ramload = J; ramstate = FREE;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RST = 1'b1;
        iREN = 1; dREN = 1; iaddr = 32'h40; daddr = 32'h10C; ramstate = ACCESS;
        #1;
        check("reset ramREN", 32'(ramREN), 32'd0);
        check("reset ramWEN", 32'(ramWEN), 32'd0);
        check("reset ramaddr", ramaddr, 32'd0);
        check("reset iwait", 32'(iwait), 32'd1);
        check("reset dwait", 32'(dwait), 32'd1);
        check("reset dload", dload, 32'd0);
        @(negedge CLK);
        idle_inputs();
        RST = 1'b0;
    endtask

    logic [31:0] exp_addr;

    initial begin
        RST = 1'b0;
        idle_inputs();
        #2 RST = 1'b1;

        // Icache single word: two BUSY cycles then ACCESS
        vecs.push_back(mk(1,32'h40,0,0,0,0,J,FREE,            0,0,0,0,1,1,0,0));
        vecs.push_back(mk(1,32'h40,0,0,0,0,J,BUSY,            1,0,32'h40,0,1,1,0,0));
        vecs.push_back(mk(1,32'h40,0,0,0,0,J,BUSY,            1,0,32'h40,0,1,1,0,0));
        vecs.push_back(mk(1,32'h40,0,0,0,0,32'hDEADBEEF,ACCESS,1,0,32'h40,0,0,1,32'hDEADBEEF,0));
        vecs.push_back(mk(0,0,0,0,0,0,J,FREE,                 0,0,0,0,1,1,0,0));
        // Simultaneous requests: dcache first, icache after one IDLE cycle
        vecs.push_back(mk(1,32'h80,1,0,32'h10C,0,J,FREE,       0,0,0,0,1,1,0,0));
        vecs.push_back(mk(1,32'h80,1,0,32'h10C,0,32'h11111111,ACCESS, 1,0,32'h10C,0,1,0,0,32'h11111111));
        vecs.push_back(mk(1,32'h80,0,0,0,0,J,FREE,             0,0,0,0,1,1,0,0));
        vecs.push_back(mk(1,32'h80,0,0,0,0,32'h22222222,ACCESS,1,0,32'h80,0,0,1,32'h22222222,0));
        vecs.push_back(mk(0,0,0,0,0,0,J,FREE,                  0,0,0,0,1,1,0,0));
        // Locked fill with icache pending; ERROR on word 1 is not a completion
        vecs.push_back(mk(1,32'h80,1,0,32'h100,0,J,FREE,       0,0,0,0,1,1,0,0));
        vecs.push_back(mk(1,32'h80,1,0,32'h100,0,32'hA0,ACCESS,1,0,32'h100,0,1,0,0,32'hA0));
        vecs.push_back(mk(1,32'h80,1,0,32'h104,0,J,ERROR,      1,0,32'h104,0,1,1,0,0));
        vecs.push_back(mk(1,32'h80,1,0,32'h104,0,32'hA4,ACCESS,1,0,32'h104,0,1,0,0,32'hA4));
        vecs.push_back(mk(1,32'h80,0,0,0,0,J,FREE,             0,0,0,0,1,1,0,0));
        vecs.push_back(mk(1,32'h80,0,0,0,0,32'hB0,ACCESS,      1,0,32'h80,0,0,1,32'hB0,0));
        vecs.push_back(mk(0,0,0,0,0,0,J,FREE,                  0,0,0,0,1,1,0,0));
        // Write-back word 0, then dWEN dropped in DLOCK releases the lock
        vecs.push_back(mk(0,0,0,1,32'h208,32'h12345678,J,FREE, 0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,0,0,1,32'h208,32'h12345678,32'h5A5A5A5A,ACCESS,
                          0,1,32'h208,32'h12345678,1,0,0,32'h5A5A5A5A));
        vecs.push_back(mk(0,0,0,0,0,0,J,FREE,                  0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,0,0,1,32'h20C,32'h87654321,J,ACCESS,0,0,0,0,1,1,0,0));
        vecs.push_back(mk(0,0,0,1,32'h20C,32'h87654321,J,ACCESS,
                          0,1,32'h20C,32'h87654321,1,0,0,J));
        vecs.push_back(mk(0,0,0,0,0,0,J,FREE,                  0,0,0,0,1,1,0,0));

        do_reset();

        foreach (vecs[i]) begin
            @(negedge CLK);
            drive(vecs[i]);
            #1;
            check_all($sformatf("v%0d", i), vecs[i]);
        end

        // Both caches request single words continuously
        do_reset();
        for (int k = 0; k < 8; k++) begin
            @(negedge CLK);
            iREN = 1; iaddr = 32'h40; dREN = 1; daddr = 32'h10C; ramstate = ACCESS;
            #1;
            if (k % 2 == 0) begin
                check($sformatf("alt%0d idle ramREN", k), 32'(ramREN), 32'd0);
            end else begin
`ifdef CACHE_ARB_RR_EN
                exp_addr = ((k / 2) % 2 == 0) ? 32'h10C : 32'h40;
`else
                exp_addr = 32'h10C;
`endif
                check($sformatf("alt%0d ramaddr", k), ramaddr, exp_addr);
            end
        end

        // Reset asserted while dcache holds the port
        do_reset();
        @(negedge CLK);
        dREN = 1; daddr = 32'h10C; ramstate = FREE;
        @(negedge CLK);
        ramstate = BUSY;
        #1;
        check("pre-rst ramREN", 32'(ramREN), 32'd1);
        RST = 1'b1;
        #1;
        check("mid-rst ramREN", 32'(ramREN), 32'd0);
        check("mid-rst dwait", 32'(dwait), 32'd1);
        check("mid-rst ramaddr", ramaddr, 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        #1;
        check("post-rst idle ramREN", 32'(ramREN), 32'd0);
        @(negedge CLK);
        #1;
        check("post-rst regrant ramREN", 32'(ramREN), 32'd1);
        check("post-rst regrant ramaddr", ramaddr, 32'h10C);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
